// File: rtl/game_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_pkg : screen bounds, coordinate type and rocket slot states
// Revision : 1.0
// ---------------------------------------------------------------------------
package game_pkg;

  localparam logic [9:0] MinX = 10'd0;
  localparam logic [9:0] MaxX = 10'd639;
  localparam logic [9:0] MinY = 10'd0;
  localparam logic [9:0] MaxY = 10'd479;

  typedef logic [9:0] coord_t;

  typedef enum logic [0:0] {
    Idle   = 1'b0,
    Flying = 1'b1
  } rock_state_t;

endpackage
`default_nettype wire

// File: rtl/player_rocket_slot.sv
`default_nettype none
// ---------------------------------------------------------------------------
// player_rocket_slot : one rocket slot - launch, upward move, retire, pixel match
// Revision : 1.0
// ---------------------------------------------------------------------------
module player_rocket_slot
  import game_pkg::*;
#(
  parameter coord_t ROCK_X_SIZE = 10'd3,
  parameter coord_t ROCK_Y_SIZE = 10'd8,
  parameter coord_t ROCK_Y_STEP = 10'd4
) (
  input  logic   frame_clk,
  input  logic   Reset,
  input  logic   launch,
  input  coord_t launch_x,
  input  coord_t launch_y,
  input  logic   hit,
  input  coord_t draw_x,
  input  coord_t draw_y,
  output logic   active,
  output coord_t pos_x,
  output coord_t pos_y,
  output logic   match
);

  rock_state_t state_q, state_d;
  coord_t      x_q, x_d, y_q, y_d;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      Idle: begin
        if (launch) begin
          state_d = Flying;
          x_d     = launch_x;
          y_d     = launch_y;
        end
      end
      Flying: begin
        // Top-edge test happens before the subtract so Y never wraps
        if (hit) begin
          state_d = Idle;
        end else if (y_q < ROCK_Y_STEP) begin
          state_d = Idle;
        end else begin
          y_d = y_q - ROCK_Y_STEP;
        end
      end
      default: state_d = Idle;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= Idle;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign active = (state_q == Flying);
  assign pos_x  = x_q;
  assign pos_y  = y_q;
  assign match  = active &&
                  (draw_x >= x_q) && (draw_x <= x_q + ROCK_X_SIZE) &&
                  (draw_y >= y_q) && (draw_y <= y_q + ROCK_Y_SIZE);

endmodule
`default_nettype wire

// File: rtl/player_rocket_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// player_rocket_ctrl : player rocket pool - fire edge, cooldown, allocation,
//                      pixel priority mux. Optional ammo via PLAYER_ROCK_AMMO_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
module player_rocket_ctrl
  import game_pkg::*;
#(
  parameter int     NUM_ROCK      = 8,
  parameter coord_t ROCK_X_SIZE   = 10'd3,
  parameter coord_t ROCK_Y_SIZE   = 10'd8,
  parameter coord_t ROCK_Y_STEP   = 10'd4,
  parameter coord_t GUN_X_OFFSET  = 10'd5,
  parameter int     COOLDOWN      = 10,
  parameter int     MAG_SIZE      = 5,
  parameter int     RELOAD_FRAMES = 60
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                Fire_btn,
  input  logic [9:0]          PlayerX,
  input  logic [9:0]          PlayerY,
  input  logic [9:0]          DrawX,
  input  logic [9:0]          DrawY,
  input  logic [NUM_ROCK-1:0] Rock_hit,
  output logic [NUM_ROCK-1:0] is_PlayerRock,
  output logic [9:0]          PlayerRockDistX,
  output logic [9:0]          PlayerRockDistY,
  output logic [NUM_ROCK-1:0] Rock_active,
  output logic [3:0]          Ammo,
  output logic                Fire_blocked
);

  localparam int         CD_W = 16;
  localparam logic [3:0] MAG4 = 4'(MAG_SIZE);

  if (NUM_ROCK < 1 || NUM_ROCK > 16 || RELOAD_FRAMES < 1) begin : g_param_check
    $error("player_rocket_ctrl: parameter out of range");
  end

  logic            fire_prev_q, fire_prev_d;
  logic            fire_blocked_q, fire_blocked_d;
  logic [CD_W-1:0] cooldown_q, cooldown_d;
  logic            fire_edge, any_idle, launch_ok, ammo_ok;
  logic [NUM_ROCK-1:0] first_idle, launch_vec, slot_match;
  coord_t          slot_x [NUM_ROCK];
  coord_t          slot_y [NUM_ROCK];
  coord_t          launch_x, launch_y;

  assign launch_x = PlayerX + GUN_X_OFFSET;
  assign launch_y = PlayerY - ROCK_Y_SIZE - 10'd1;

  always_comb begin
    fire_edge  = Fire_btn & ~fire_prev_q;
    any_idle   = 1'b0;
    first_idle = '0;
    for (int i = 0; i < NUM_ROCK; i++) begin
      if (!Rock_active[i] && !any_idle) begin
        any_idle      = 1'b1;
        first_idle[i] = 1'b1;
      end
    end
    launch_ok      = fire_edge && (cooldown_q == '0) && any_idle && ammo_ok;
    launch_vec     = launch_ok ? first_idle : '0;
    fire_blocked_d = fire_edge & ~launch_ok;
    fire_prev_d    = Fire_btn;
    if (launch_ok) begin
      cooldown_d = CD_W'(COOLDOWN);
    end else if (cooldown_q != '0) begin
      cooldown_d = cooldown_q - CD_W'(1);
    end else begin
      cooldown_d = '0;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      fire_prev_q    <= 1'b1;
      fire_blocked_q <= 1'b0;
      cooldown_q     <= '0;
    end else begin
      fire_prev_q    <= fire_prev_d;
      fire_blocked_q <= fire_blocked_d;
      cooldown_q     <= cooldown_d;
    end
  end

  assign Fire_blocked = fire_blocked_q;

`ifdef PLAYER_ROCK_AMMO_EN
  logic [3:0]  ammo_q, ammo_d;
  logic [15:0] reload_q, reload_d;
  logic        refill;

  // A launch and a refill in the same frame cancel out
  always_comb begin
    refill   = (ammo_q < MAG4) && (reload_q == 16'(RELOAD_FRAMES - 1));
    reload_d = ((ammo_q == MAG4) || refill) ? '0 : reload_q + 16'd1;
    ammo_d   = ammo_q;
    if (refill && !launch_ok) begin
      ammo_d = ammo_q + 4'd1;
    end else if (launch_ok && !refill) begin
      ammo_d = ammo_q - 4'd1;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      ammo_q   <= MAG4;
      reload_q <= '0;
    end else begin
      ammo_q   <= ammo_d;
      reload_q <= reload_d;
    end
  end

  assign ammo_ok = (ammo_q != 4'd0);
  assign Ammo    = ammo_q;
`else
  assign ammo_ok = 1'b1;
  assign Ammo    = MAG4;
`endif

  for (genvar i = 0; i < NUM_ROCK; i++) begin : g_slot
    player_rocket_slot #(
      .ROCK_X_SIZE (ROCK_X_SIZE),
      .ROCK_Y_SIZE (ROCK_Y_SIZE),
      .ROCK_Y_STEP (ROCK_Y_STEP)
    ) u_slot (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .launch    (launch_vec[i]),
      .launch_x  (launch_x),
      .launch_y  (launch_y),
      .hit       (Rock_hit[i]),
      .draw_x    (DrawX),
      .draw_y    (DrawY),
      .active    (Rock_active[i]),
      .pos_x     (slot_x[i]),
      .pos_y     (slot_y[i]),
      .match     (slot_match[i])
    );
  end

  always_comb begin
    is_PlayerRock   = '0;
    PlayerRockDistX = '0;
    PlayerRockDistY = '0;
    for (int i = NUM_ROCK - 1; i >= 0; i--) begin
      if (slot_match[i]) begin
        is_PlayerRock    = '0;
        is_PlayerRock[i] = 1'b1;
        PlayerRockDistX  = DrawX - slot_x[i];
        PlayerRockDistY  = DrawY - slot_y[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_player_rocket_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_player_rocket_ctrl : scoreboard bench with a frame-level reference model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_player_rocket_ctrl;

  localparam int N = 8;
`ifdef PLAYER_ROCK_AMMO_EN
  localparam bit AMMO_EN = 1'b1;
`else
  localparam bit AMMO_EN = 1'b0;
`endif

  logic         frame_clk = 1'b0;
  logic         Reset, Fire_btn;
  logic [9:0]   PlayerX, PlayerY, DrawX, DrawY;
  logic [N-1:0] Rock_hit, is_PlayerRock, Rock_active;
  logic [9:0]   PlayerRockDistX, PlayerRockDistY;
  logic [3:0]   Ammo;
  logic         Fire_blocked;

  always #5 frame_clk = ~frame_clk;

  player_rocket_ctrl dut (
    .frame_clk       (frame_clk),
    .Reset           (Reset),
    .Fire_btn        (Fire_btn),
    .PlayerX         (PlayerX),
    .PlayerY         (PlayerY),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .Rock_hit        (Rock_hit),
    .is_PlayerRock   (is_PlayerRock),
    .PlayerRockDistX (PlayerRockDistX),
    .PlayerRockDistY (PlayerRockDistY),
    .Rock_active     (Rock_active),
    .Ammo            (Ammo),
    .Fire_blocked    (Fire_blocked)
  );

  typedef struct {
    logic [N-1:0] act;
    logic         blk;
    logic [3:0]   ammo;
    logic [N-1:0] flag;
    logic [9:0]   ddx;
    logic [9:0]   ddy;
  } exp_t;

  exp_t q[$];
  int n_pass = 0;
  int n_total = 0;

  // Reference model: plain per-frame rules over integer arrays
  bit m_fly [N];
  int m_x [N];
  int m_y [N];
  int m_cd, m_ammo, m_reload;
  bit m_prev, m_blk;
  int px = 300, py = 440;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_fly[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_cd = 0; m_prev = 1; m_blk = 0; m_ammo = 5; m_reload = 0;
  endfunction

  function automatic void model_next(bit rst, bit fire, logic [N-1:0] hit);
    int slot;
    bit fedge, ok, refill;
    if (rst) begin
      model_reset();
      return;
    end
    fedge = fire && !m_prev;
    slot = -1;
    for (int i = 0; i < N; i++) if (!m_fly[i] && slot < 0) slot = i;
    ok = fedge && m_cd == 0 && slot >= 0 && (!AMMO_EN || m_ammo > 0);
    for (int i = 0; i < N; i++) begin
      if (m_fly[i]) begin
        if (hit[i]) m_fly[i] = 0;
        else if (m_y[i] < 4) m_fly[i] = 0;
        else m_y[i] = m_y[i] - 4;
      end
    end
    if (ok) begin
      m_fly[slot] = 1;
      m_x[slot] = (px + 5) % 1024;
      m_y[slot] = py - 9;
    end
    m_cd = ok ? 10 : (m_cd > 0 ? m_cd - 1 : 0);
    m_blk = fedge && !ok;
    if (AMMO_EN) begin
      refill = (m_ammo < 5) && (m_reload == 59);
      m_reload = (m_ammo == 5 || refill) ? 0 : m_reload + 1;
      m_ammo = m_ammo + int'(refill) - int'(ok);
    end
    m_prev = fire;
  endfunction

  function automatic void exp_pixel(int qx, int qy, output logic [N-1:0] f,
                                    output logic [9:0] ex, output logic [9:0] ey);
    f = '0; ex = '0; ey = '0;
    for (int i = 0; i < N; i++) begin
      if (f == '0 && m_fly[i] && qx >= m_x[i] && qx <= m_x[i] + 3 &&
          qy >= m_y[i] && qy <= m_y[i] + 8) begin
        f[i] = 1'b1;
        ex = 10'(qx - m_x[i]);
        ey = 10'(qy - m_y[i]);
      end
    end
  endfunction

  task automatic step(bit rst, bit fire, logic [N-1:0] hit, int qx = -1, int qy = -1);
    exp_t e;
    int fl[$];
    int k;
    if (qx < 0) begin
      for (int i = 0; i < N; i++) if (m_fly[i]) fl.push_back(i);
      if (fl.size() > 0 && ($urandom % 4) != 0) begin
        k = fl[$urandom % fl.size()];
        qx = m_x[k] - 1 + int'($urandom_range(0, 5));
        qy = m_y[k] - 1 + int'($urandom_range(0, 10));
      end else begin
        qx = int'($urandom_range(0, 639));
        qy = int'($urandom_range(0, 479));
      end
      if (qx < 0) qx = 0;
      if (qy < 0) qy = 0;
    end
    Reset = rst; Fire_btn = fire; Rock_hit = hit;
    PlayerX = 10'(px); PlayerY = 10'(py);
    DrawX = 10'(qx); DrawY = 10'(qy);
    for (int i = 0; i < N; i++) e.act[i] = m_fly[i];
    e.blk = m_blk;
    e.ammo = 4'(AMMO_EN ? m_ammo : 5);
    exp_pixel(qx, qy, e.flag, e.ddx, e.ddy);
    q.push_back(e);
    model_next(rst, fire, hit);
    @(posedge frame_clk);
    #1;
  endtask

  task automatic pulse();
    step(0, 1, '0);
    step(0, 0, '0);
  endtask

  task automatic idle_frames(int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  function automatic void check(string nm, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endfunction

  always @(negedge frame_clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("Rock_active",     16'(Rock_active),     16'(e.act));
      check("Fire_blocked",    16'(Fire_blocked),    16'(e.blk));
      check("Ammo",            16'(Ammo),            16'(e.ammo));
      check("is_PlayerRock",   16'(is_PlayerRock),   16'(e.flag));
      check("PlayerRockDistX", 16'(PlayerRockDistX), 16'(e.ddx));
      check("PlayerRockDistY", 16'(PlayerRockDistY), 16'(e.ddy));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1; Fire_btn = 1; Rock_hit = '0;
    PlayerX = 10'd300; PlayerY = 10'd440; DrawX = '0; DrawY = '0;
    @(posedge frame_clk); @(posedge frame_clk); #1;
    model_reset();

    // Button held through reset must not fire; then a clean pulse
    step(0, 1, '0);
    step(0, 0, '0);
    pulse();
    step(0, 0, '0, 305, 431);
    idle_frames(9);
    step(0, 0, '0, 305, 391);

    // Held button and every-frame toggling
    for (int i = 0; i < 30; i++) step(0, 1, '0);
    for (int i = 0; i < 40; i++) step(0, bit'(i % 2), '0);

    // Let everything fly off the top
    idle_frames(130);

    // Reset mid-flight
    pulse();
    idle_frames(5);
    step(1, 0, '0);
    step(0, 0, '0);

    // Hit plus fire edge in the same frame: freed slot is not reused
    pulse(); idle_frames(10);
    pulse(); idle_frames(10);
    step(0, 1, 8'h01);
    idle_frames(3);

    // Overlapping slots 1 and 3
    step(1, 0, '0);
    step(0, 0, '0);
    px = 300; py = 440;
    pulse(); idle_frames(10);
    pulse(); idle_frames(10);
    pulse(); idle_frames(10);
    py = 344;
    pulse();
    step(0, 0, '0, m_x[1] + 2, m_y[1] + 5);
    step(0, 0, '0, m_x[1] + 10, m_y[1] + 5);
    py = 440;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [N-1:0] h;
      if (i % 50 == 0) begin
        px = int'($urandom_range(0, 600));
        py = int'($urandom_range(100, 470));
      end
      h = '0;
      if (($urandom % 8) == 0) h[$urandom % N] = 1'b1;
      step(0, ($urandom % 3) == 0, h);
    end

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge frame_clk);
    #1;
    n_total++;
    if (q.size() != 0)
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
